fetch: RTL

Instruction fetch stage: owns the program counter, issues word reads to instruction memory over a request/grant/response handshake, and presents in-order `{pc, insn}` pairs to the decode stage through a valid/ready interface. It is the producer side of decode's `pc_i`/`insn_i` inputs. It sits between the instruction memory port and decode. It absorbs memory latency and decode back-pressure with a 2-entry buffer, and handles control-flow redirects by flushing buffered words and discarding in-flight responses.

---
 rtl/fetch.sv | 91 +++++++++
 1 files changed

// File: rtl/fetch.sv
// Instruction fetch: PC owner, issues credit-limited word reads and buffers up to two
// {pc, insn} pairs for decode; redirects flush the buffer and discard in-flight responses.
module fetch #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(32'h0100_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o
);

  logic [AWIDTH-1:0] pc_q;
  logic [1:0]        inflight;
  logic [1:0]        drop;
  logic [1:0]        count;
  logic              head;
  logic              tag_rd;
  logic              run;
  logic [AWIDTH-1:0] tag_mem  [2];
  logic [AWIDTH-1:0] fifo_pc  [2];
  logic [DWIDTH-1:0] fifo_insn[2];

  logic grant, resp, push, pop;
  logic tag_wr, fifo_wr;

  // Credits count dropped responses too, so the buffer can never overflow.
  assign imem_req_o   = run && !redirect_i && (({1'b0, inflight} + {1'b0, count}) < 3'd2);
  assign imem_addr_o  = pc_q;
  assign insn_valid_o = (count != 2'd0);
  assign insn_o       = fifo_insn[head];
  assign pc_o         = fifo_pc[head];

  assign grant   = imem_req_o && imem_gnt_i;
  // A response with nothing outstanding belongs to a pre-reset request and is ignored.
  assign resp    = imem_rvalid_i && (inflight != 2'd0);
  assign push    = resp && (drop == 2'd0) && !redirect_i;
  assign pop     = insn_valid_o && insn_ready_i;
  assign tag_wr  = tag_rd ^ inflight[0];
  assign fifo_wr = head ^ count[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= BASEADDR;
      inflight <= 2'd0;
      drop     <= 2'd0;
      count    <= 2'd0;
      head     <= 1'b0;
      tag_rd   <= 1'b0;
      run      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tag_mem[i]   <= '0;
        fifo_pc[i]   <= '0;
        fifo_insn[i] <= '0;
      end
    end else begin
      run      <= 1'b1;
      inflight <= inflight + {1'b0, grant} - {1'b0, resp};
      if (grant) tag_mem[tag_wr] <= pc_q;
      if (resp)  tag_rd <= ~tag_rd;
      if (pop)   head <= ~head;

      if (redirect_i) begin
        pc_q  <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
        count <= 2'd0;
        drop  <= inflight - {1'b0, resp};
      end else begin
        if (grant) pc_q <= pc_q + AWIDTH'(4);
        if (resp && drop != 2'd0) drop <= drop - 2'd1;
        if (push) begin
          fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
          fifo_insn[fifo_wr] <= imem_rdata_i;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count == 2'd2));

endmodule
